// File: rtl/dcache_sa_wb.sv
// Set-associative write-back/write-allocate data cache with per-set round-robin replacement and full flush.
// Latency: hit completes the cycle after acceptance; misses add optional write-back plus fill, then one response cycle.
// Backpressure: ready is high only in IDLE; memory commands are held until mem_res_ready.
module dcache_sa_wb #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int LINE_W = 128,
   parameter int SETS   = 512,
   parameter int WAYS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   output logic              ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rw,
   input  logic [WORD_W-1:0] wdata,
   input  logic [WORD_W-1:0] wmask,
   output logic [WORD_W-1:0] rdata,
   output logic              rvalid,
   input  logic              flush,
   output logic              flush_done,
   output logic              mem_req_valid,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [LINE_W-1:0] mem_req_data,
   input  logic              mem_res_ready,
   input  logic [LINE_W-1:0] mem_res_data
);

   localparam int OFF   = $clog2(LINE_W/8);
   localparam int IDX   = $clog2(SETS);
   localparam int TAG   = ADDR_W - IDX - OFF;
   localparam int NWORD = LINE_W / WORD_W;
   localparam int BOFF  = $clog2(WORD_W/8);
   localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP, S_FLUSH_RD, S_FLUSH_CHK, S_FLUSH_WB
   } state_t;

   state_t state, state_n;

   // tag/data storage, synchronous read, not reset
   logic [TAG-1:0]    tag_mem  [WAYS][SETS];
   logic [LINE_W-1:0] data_mem [WAYS][SETS];
   logic [TAG-1:0]    tag_q    [WAYS];
   logic [LINE_W-1:0] data_q   [WAYS];

   // line state and replacement pointers, reset
   logic [SETS-1:0]   vld [WAYS];
   logic [SETS-1:0]   dty [WAYS];
   logic [WAYW-1:0]   rr  [SETS];

   // latched request and miss bookkeeping
   logic [ADDR_W-1:0] req_addr;
   logic              req_rw;
   logic [WORD_W-1:0] req_wdata;
   logic [WORD_W-1:0] req_wmask;
   logic [WAYW-1:0]   vic_way;
   logic              vic_fresh;
   logic [LINE_W-1:0] line_q;
   logic [IDX-1:0]    set_cnt;
   logic [WAYW-1:0]   way_cnt;

   logic [TAG-1:0]    req_tag;
   logic [IDX-1:0]    req_idx;
   logic [OFF-1:0]    req_boff;

   assign req_tag  = req_addr[ADDR_W-1 -: TAG];
   assign req_idx  = req_addr[OFF +: IDX];
   assign req_boff = req_addr[OFF-1:0];

   // control strobes from the FSM
   logic              rd_en;
   logic [IDX-1:0]    rd_idx;
   logic              arr_we;
   logic [WAYW-1:0]   arr_way;
   logic [LINE_W-1:0] arr_line;
   logic              st_we;
   logic [WAYW-1:0]   st_way;
   logic [IDX-1:0]    st_idx;
   logic              st_v;
   logic              st_d;
   logic              rr_adv;
   logic              step;

   logic              hit;
   logic [WAYW-1:0]   hit_way;
   logic              any_inv;
   logic [WAYW-1:0]   inv_way;
   logic [WAYW-1:0]   vic_sel;
   logic [LINE_W-1:0] hit_line;
   logic [LINE_W-1:0] fill_line;

   function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF-1:0]    boff);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int i = 0; i < NWORD; i++)
         if (int'(boff >> BOFF) == i) r = line[i*WORD_W +: WORD_W];
      return r;
   endfunction

   function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF-1:0]    boff,
                                                    input logic [WORD_W-1:0] d,
                                                    input logic [WORD_W-1:0] m);
      logic [LINE_W-1:0] r;
      r = line;
      for (int i = 0; i < NWORD; i++)
         if (int'(boff >> BOFF) == i)
            r[i*WORD_W +: WORD_W] = (line[i*WORD_W +: WORD_W] & ~m) | (d & m);
      return r;
   endfunction

   // tag compare across ways; the descending scan leaves the lowest matching/invalid way
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      any_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (vld[w][req_idx] && (tag_q[w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAYW'(w);
         end
         if (!vld[w][req_idx]) begin
            any_inv = 1'b1;
            inv_way = WAYW'(w);
         end
      end
   end

   assign vic_sel   = any_inv ? inv_way : rr[req_idx];
   assign hit_line  = merge_word(data_q[hit_way], req_boff, req_wdata, req_wmask);
   assign fill_line = req_rw ? merge_word(mem_res_data, req_boff, req_wdata, req_wmask)
                             : mem_res_data;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // next-state, outputs and storage strobes
   always_comb begin
      state_n       = state;
      ready         = 1'b0;
      rvalid        = 1'b0;
      rdata         = '0;
      flush_done    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      mem_req_addr  = '0;
      mem_req_data  = '0;
      rd_en         = 1'b0;
      rd_idx        = addr[OFF +: IDX];
      arr_we        = 1'b0;
      arr_way       = vic_way;
      arr_line      = fill_line;
      st_we         = 1'b0;
      st_way        = vic_way;
      st_idx        = req_idx;
      st_v          = 1'b0;
      st_d          = 1'b0;
      rr_adv        = 1'b0;
      step          = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (flush) begin
               state_n = S_FLUSH_RD;
            end else if (valid) begin
               rd_en   = 1'b1;
               state_n = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               rvalid  = 1'b1;
               state_n = S_IDLE;
               if (req_rw) begin
                  arr_we   = 1'b1;
                  arr_way  = hit_way;
                  arr_line = hit_line;
                  st_we    = 1'b1;
                  st_way   = hit_way;
                  st_v     = 1'b1;
                  st_d     = 1'b1;
                  rdata    = get_word(hit_line, req_boff);
               end else begin
                  rdata    = get_word(data_q[hit_way], req_boff);
               end
            end else begin
               state_n = dty[vic_sel][req_idx] ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            mem_req_addr  = {tag_q[vic_way], req_idx, {OFF{1'b0}}};
            mem_req_data  = data_q[vic_way];
            if (mem_res_ready) state_n = S_FILL;
         end
         S_FILL: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {req_tag, req_idx, {OFF{1'b0}}};
            if (mem_res_ready) begin
               arr_we  = 1'b1;
               st_we   = 1'b1;
               st_v    = 1'b1;
               st_d    = req_rw;
               rr_adv  = !vic_fresh;
               state_n = S_RESP;
            end
         end
         S_RESP: begin
            rvalid  = 1'b1;
            rdata   = get_word(line_q, req_boff);
            state_n = S_IDLE;
         end
         S_FLUSH_RD: begin
            rd_en   = 1'b1;
            rd_idx  = set_cnt;
            state_n = S_FLUSH_CHK;
         end
         S_FLUSH_CHK: begin
            if (dty[way_cnt][set_cnt]) begin
               state_n = S_FLUSH_WB;
            end else begin
               st_we  = 1'b1;
               st_way = way_cnt;
               st_idx = set_cnt;
               step   = 1'b1;
            end
         end
         S_FLUSH_WB: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            mem_req_addr  = {tag_q[way_cnt], set_cnt, {OFF{1'b0}}};
            mem_req_data  = data_q[way_cnt];
            if (mem_res_ready) begin
               st_we  = 1'b1;
               st_way = way_cnt;
               st_idx = set_cnt;
               step   = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // flush walk: ways within a set, then the next set, then done
      if (step) begin
         if (way_cnt == WAYW'(WAYS-1)) begin
            if (set_cnt == IDX'(SETS-1)) begin
               flush_done = 1'b1;
               state_n    = S_IDLE;
            end else begin
               state_n    = S_FLUSH_RD;
            end
         end else begin
            state_n = S_FLUSH_CHK;
         end
      end
   end

   // request latch, victim bookkeeping, line state, rr pointers and flush counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr  <= '0;
         req_rw    <= 1'b0;
         req_wdata <= '0;
         req_wmask <= '0;
         vic_way   <= '0;
         vic_fresh <= 1'b0;
         line_q    <= '0;
         set_cnt   <= '0;
         way_cnt   <= '0;
         for (int w = 0; w < WAYS; w++) begin
            vld[w] <= '0;
            dty[w] <= '0;
         end
         for (int s = 0; s < SETS; s++) rr[s] <= '0;
      end else begin
         if (state == S_IDLE && flush) begin
            set_cnt <= '0;
            way_cnt <= '0;
         end else if (state == S_IDLE && valid) begin
            req_addr  <= addr;
            req_rw    <= rw;
            req_wdata <= wdata;
            req_wmask <= wmask;
         end
         if (state == S_LOOKUP && !hit) begin
            vic_way   <= vic_sel;
            vic_fresh <= any_inv;
         end
         if (state == S_FILL && mem_res_ready) line_q <= fill_line;
         if (st_we) begin
            vld[st_way][st_idx] <= st_v;
            dty[st_way][st_idx] <= st_d;
         end
         if (rr_adv) rr[req_idx] <= (WAYS == 1) ? '0 : rr[req_idx] + 1'b1;
         if (step) begin
            if (way_cnt == WAYW'(WAYS-1)) begin
               way_cnt <= '0;
               set_cnt <= set_cnt + 1'b1;
            end else begin
               way_cnt <= way_cnt + 1'b1;
            end
         end
      end
   end

   // tag/data arrays: one-cycle registered read, single write port
   always_ff @(posedge clk) begin
      if (rd_en) begin
         for (int w = 0; w < WAYS; w++) begin
            tag_q[w]  <= tag_mem[w][rd_idx];
            data_q[w] <= data_mem[w][rd_idx];
         end
      end
      if (arr_we) begin
         tag_mem[arr_way][req_idx]  <= req_tag;
         data_mem[arr_way][req_idx] <= arr_line;
      end
   end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Directed bench for dcache_sa_wb: scoreboard queues for CPU responses and memory commands.
// A memory model answers commands after a programmable delay and records write-backs.
// Stimulus pushes expectations; monitors pop and compare as the DUT presents outputs.
module tb_dcache_sa_wb;

   typedef struct packed {
      logic         rw;
      logic [31:0]  addr;
      logic [127:0] data;
   } mcmd_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid, ready, rw, rvalid, flush, flush_done;
   logic [31:0]  addr, wdata, wmask, rdata;
   logic         mem_req_valid, mem_req_rw, mem_res_ready;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_data, mem_res_data;

   int vectors = 0;
   int miscompares = 0;
   int fd_cnt = 0;
   int resp_delay = 2;
   logic mem_busy = 1'b0;

   logic [31:0]  exp_rd [$];
   mcmd_t        exp_mem [$];
   logic [127:0] mem_model [logic [31:0]];

   always #5 clk = ~clk;

   dcache_sa_wb dut (
      .clk(clk), .rst(rst), .valid(valid), .ready(ready), .addr(addr), .rw(rw),
      .wdata(wdata), .wmask(wmask), .rdata(rdata), .rvalid(rvalid), .flush(flush),
      .flush_done(flush_done), .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic bad(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s", name);
   endtask

   // unwritten memory lines: word i = {line_addr[15:0], i}
   function automatic logic [127:0] model_rd(input logic [31:0] a);
      logic [127:0] l;
      if (mem_model.exists(a)) return mem_model[a];
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = {a[15:0], 16'(i)};
      return l;
   endfunction

   // CPU response monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rvalid) begin
               if (exp_rd.size() == 0) bad("unexpected_rvalid");
               else chk("rdata", rdata, exp_rd.pop_front());
            end else if (rdata !== 32'h0) begin
               chk("rdata_zero_when_idle", rdata, 0);
            end
            if (flush_done) fd_cnt++;
         end
      end
   end

   // memory model and command monitor
   initial begin
      logic        cur_rw;
      logic [31:0] cur_addr;
      int          cnt;
      mcmd_t       e;
      mem_res_ready = 1'b0;
      mem_res_data  = '0;
      cur_rw = 1'b0; cur_addr = '0; cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_busy      = 1'b0;
            mem_res_ready = 1'b0;
         end else begin
            if (mem_res_ready) begin
               mem_res_ready = 1'b0;
               mem_busy      = 1'b0;
            end
            if (!mem_busy && mem_req_valid) begin
               mem_busy = 1'b1;
               cur_rw   = mem_req_rw;
               cur_addr = mem_req_addr;
               cnt      = resp_delay;
               if (exp_mem.size() == 0) begin
                  bad("unexpected_mem_cmd");
               end else begin
                  e = exp_mem.pop_front();
                  chk("mem_rw", mem_req_rw, e.rw);
                  chk("mem_addr", mem_req_addr, e.addr);
                  if (e.rw) chk("mem_wb_data", mem_req_data, e.data);
               end
               if (cur_rw) mem_model[cur_addr] = mem_req_data;
            end else if (mem_busy) begin
               if (cnt == 0) begin
                  mem_res_ready = 1'b1;
                  mem_res_data  = cur_rw ? 128'h0 : model_rd(cur_addr);
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!ready) bad("timeout_ready");
   endtask

   task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] m);
      wait_ready();
      valid = 1'b1; rw = r; addr = a; wdata = d; wmask = m;
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] expd);
      exp_rd.push_back(expd);
      issue(1'b0, a, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m,
                     input logic [31:0] expd);
      exp_rd.push_back(expd);
      issue(1'b1, a, d, m);
   endtask

   task automatic xm(input logic r, input logic [31:0] a, input logic [127:0] d);
      exp_mem.push_back('{rw: r, addr: a, data: d});
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((!ready || mem_busy || exp_rd.size() != 0) && n < 3000);
      if (n >= 3000) bad("timeout_idle");
   endtask

   task automatic hit_rd(input logic [31:0] a, input logic [31:0] expd);
      rd(a, expd);
      @(negedge clk);
      chk("hit_rvalid_at_n1", rvalid, 1'b1);
      chk("hit_no_mem_traffic", mem_req_valid, 1'b0);
   endtask

   initial begin
      int n;
      valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0; wmask = '0; flush = 1'b0;
      mem_model[32'h1000] = {32'hDDCCBBAA, 32'h99887766, 32'h55443322, 32'h11223344};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 1'b1);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", rdata, 0);
      chk("rst_flush_done", flush_done, 1'b0);
      chk("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_mem_req_rw", mem_req_rw, 1'b0);
      rst = 1'b0;

      // cold read miss, then hits
      xm(1'b0, 32'h1000, '0);
      rd(32'h1004, 32'h55443322);
      wait_idle();
      hit_rd(32'h100C, 32'hDDCCBBAA);
      wait_idle();

      // masked write hit and read-back
      wr(32'h1000, 32'h12345678, 32'h0000FFFF, 32'h11225678);
      wait_idle();
      hit_rd(32'h1000, 32'h11225678);
      wait_idle();

      // set 0x010: two write misses (dirty), then two conflicting misses evict way0, way1
      xm(1'b0, 32'h0100, '0);
      wr(32'h0104, 32'hCAFE0001, 32'hFFFFFFFF, 32'hCAFE0001);
      xm(1'b0, 32'h2100, '0);
      wr(32'h2108, 32'hBEEF0002, 32'hFFFFFFFF, 32'hBEEF0002);
      xm(1'b1, 32'h0100, {32'h01000003, 32'h01000002, 32'hCAFE0001, 32'h01000000});
      xm(1'b0, 32'h4100, '0);
      rd(32'h4100, 32'h41000000);
      xm(1'b1, 32'h2100, {32'h21000003, 32'hBEEF0002, 32'h21000001, 32'h21000000});
      xm(1'b0, 32'h6100, '0);
      rd(32'h610C, 32'h61000003);
      xm(1'b0, 32'h0100, '0);
      rd(32'h0104, 32'hCAFE0001);
      wait_idle();

      // two more dirty lines, then flush
      xm(1'b0, 32'h0200, '0);
      wr(32'h0200, 32'h000000EE, 32'h000000FF, 32'h020000EE);
      xm(1'b0, 32'h3000, '0);
      wr(32'h300C, 32'h77000000, 32'hFF000000, 32'h77000003);
      wait_idle();
      xm(1'b1, 32'h0200, {32'h02000003, 32'h02000002, 32'h02000001, 32'h020000EE});
      xm(1'b1, 32'h1000, {32'hDDCCBBAA, 32'h99887766, 32'h55443322, 32'h11225678});
      xm(1'b1, 32'h3000, {32'h77000003, 32'h30000002, 32'h30000001, 32'h30000000});
      wait_ready();
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      n = 0;
      while (fd_cnt == 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      chk("flush_done_pulses", fd_cnt, 1);
      chk("flush_wb_outstanding", exp_mem.size(), 0);

      // every line misses after flush
      xm(1'b0, 32'h1000, '0);
      rd(32'h1000, 32'h11225678);
      xm(1'b0, 32'h0200, '0);
      rd(32'h0200, 32'h020000EE);
      xm(1'b0, 32'h3000, '0);
      rd(32'h3000, 32'h30000000);
      xm(1'b0, 32'h4100, '0);
      rd(32'h4104, 32'h41000001);
      wait_idle();

      // reset during a fill
      resp_delay = 20;
      xm(1'b0, 32'h8000, '0);
      issue(1'b0, 32'h8000, 32'h0, 32'h0);
      n = 0;
      while (!(mem_req_valid && !mem_req_rw) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) bad("timeout_fill_req");
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_mid_ready", ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      resp_delay = 2;

      // lines resident before reset must miss now
      xm(1'b0, 32'h1000, '0);
      rd(32'h1004, 32'h55443322);
      xm(1'b0, 32'h0200, '0);
      rd(32'h0200, 32'h020000EE);
      wait_idle();
      repeat (4) @(negedge clk);
      chk("rdata_outstanding", exp_rd.size(), 0);
      chk("mem_outstanding", exp_mem.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
